// File: rtl/button_step_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : button_step_pulser
//  Description : Turns two raw push-buttons into clean one-cycle step commands
//                for the up/down selector counter. Each button goes through a
//                2-FF synchroniser and a debouncer. A rising debounced level
//                produces a press pulse. An optional hold-to-auto-repeat FSM
//                adds further pulses while the button stays held.
//  Ports       : clk        - system clock, rising edge
//                reset      - synchronous, active-high reset
//                btn_up     - raw asynchronous up button, active high
//                btn_down   - raw asynchronous down button, active high
//                up         - one-cycle up step pulse (registered)
//                down       - one-cycle down step pulse (registered)
//                enable     - registered, equals up | down
//                up_level   - debounced level of btn_up
//                down_level - debounced level of btn_down
//  Revision    : 1.0 - initial release
// ============================================================================
module button_step_pulser #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic enable,
  output logic up_level,
  output logic down_level
);

  // One counter width serves the debounce and the repeat counters. Counts
  // only ever reach (parameter - 1), so $clog2 of the largest parameter fits.
  localparam int c_MAX_DR = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_MAXP   = (DEBOUNCE_CYCLES > c_MAX_DR) ? DEBOUNCE_CYCLES : c_MAX_DR;
  localparam int c_CW     = (c_MAXP < 2) ? 1 : $clog2(c_MAXP);

  localparam logic [c_CW-1:0] c_DB_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_RD_LAST = c_CW'(REPEAT_DELAY - 1);
  localparam logic [c_CW-1:0] c_RP_LAST = c_CW'(REPEAT_PERIOD - 1);
  localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);
  localparam logic            c_REP_ON  = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rep_state_t;

  // Index 0 = up button, index 1 = down button.
  logic [1:0] w_btn;
  logic [1:0] w_lvl;
  logic [1:0] w_req;
  logic       w_both;
  logic       w_fire_up;
  logic       w_fire_down;
  logic       r_up;
  logic       r_down;
  logic       r_en;

  assign w_btn  = {btn_down, btn_up};
  assign w_both = w_lvl[0] & w_lvl[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_s1;
      logic            r_s2;
      logic            r_lvl;
      logic            r_lvl_d;
      logic [c_CW-1:0] r_dbc;
      logic [c_CW-1:0] r_rcnt;
      rep_state_t      r_state;
      logic            w_rise;
      logic            w_hit;

      // Synchroniser and debouncer: the synchronised value must differ from
      // the accepted level for DEBOUNCE_CYCLES consecutive edges before it is
      // taken. Any return to the current level restarts the count.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_lvl   <= 1'b0;
          r_lvl_d <= 1'b0;
          r_dbc   <= '0;
        end else begin
          r_s1    <= w_btn[gi];
          r_s2    <= r_s1;
          r_lvl_d <= r_lvl;
          if (r_s2 != r_lvl) begin
            if (r_dbc == c_DB_LAST) begin
              r_lvl <= r_s2;
              r_dbc <= '0;
            end else begin
              r_dbc <= r_dbc + c_ONE;
            end
          end else begin
            r_dbc <= '0;
          end
        end
      end

      assign w_rise = r_lvl & ~r_lvl_d;

      // Repeat pulses are suppressed while both buttons are held; the FSM
      // also pins its counter to zero then, so the timing restarts cleanly.
      assign w_hit = r_lvl & ~w_both &
                     (((r_state == ST_HOLD) && c_REP_ON && (r_rcnt == c_RD_LAST)) ||
                      ((r_state == ST_RPT) && (r_rcnt == c_RP_LAST)));

      assign w_req[gi] = w_rise | w_hit;
      assign w_lvl[gi] = r_lvl;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= ST_IDLE;
          r_rcnt  <= '0;
        end else if (!r_lvl) begin
          r_state <= ST_IDLE;
          r_rcnt  <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_rise) begin
                r_state <= ST_HOLD;
                r_rcnt  <= '0;
              end
            end
            ST_HOLD: begin
              if (w_both || !c_REP_ON) begin
                r_rcnt <= '0;
              end else if (r_rcnt == c_RD_LAST) begin
                r_state <= ST_RPT;
                r_rcnt  <= '0;
              end else begin
                r_rcnt <= r_rcnt + c_ONE;
              end
            end
            ST_RPT: begin
              if (w_both) begin
                r_state <= ST_HOLD;
                r_rcnt  <= '0;
              end else if (r_rcnt == c_RP_LAST) begin
                r_rcnt <= '0;
              end else begin
                r_rcnt <= r_rcnt + c_ONE;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_rcnt  <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  // Simultaneous requests cancel each other. A request directly after a pulse
  // from the same button is dropped so its pulses are never back to back.
  assign w_fire_up   = w_req[0] & ~w_req[1] & ~r_up;
  assign w_fire_down = w_req[1] & ~w_req[0] & ~r_down;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_en   <= 1'b0;
    end else begin
      r_up   <= w_fire_up;
      r_down <= w_fire_down;
      r_en   <= w_fire_up | w_fire_down;
    end
  end

  assign up         = r_up;
  assign down       = r_down;
  assign enable     = r_en;
  assign up_level   = w_lvl[0];
  assign down_level = w_lvl[1];

endmodule
`default_nettype wire

// File: tb/tb_button_step_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_step_pulser
//  Description : Directed self-checking bench for button_step_pulser with
//                DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8. Instance
//                u_dut0 has auto-repeat off, u_dut1 has it on.
//                Outputs are compared packed as {up,down,enable,up_lvl,dn_lvl}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_step_pulser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r_b0_up = 1'b0, r_b0_dn = 1'b0;
  logic r_b1_up = 1'b0, r_b1_dn = 1'b0;
  logic w_up0, w_dn0, w_en0, w_ul0, w_dl0;
  logic w_up1, w_dn1, w_en1, w_ul1, w_dl1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_step_pulser #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) u_dut0 (
    .clk(clk), .reset(rst), .btn_up(r_b0_up), .btn_down(r_b0_dn),
    .up(w_up0), .down(w_dn0), .enable(w_en0), .up_level(w_ul0), .down_level(w_dl0)
  );

  button_step_pulser #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) u_dut1 (
    .clk(clk), .reset(rst), .btn_up(r_b1_up), .btn_down(r_b1_dn),
    .up(w_up1), .down(w_dn1), .enable(w_en1), .up_level(w_ul1), .down_level(w_dl1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    r_b0_up = 1'b0; r_b0_dn = 1'b0;
    r_b1_up = 1'b0; r_b1_dn = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pk(input logic u, input logic d, input logic e,
                                     input logic ul, input logic dl);
    return {27'd0, u, d, e, ul, dl};
  endfunction

  initial begin
    logic eu, ed, eul, edl;
    #1;
    // 1: reset held 3 cycles with buttons low, then released.
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t1 rst dut0 k=%0d", k), pk(w_up0, w_dn0, w_en0, w_ul0, w_dl0), 32'd0);
      check($sformatf("t1 rst dut1 k=%0d", k), pk(w_up1, w_dn1, w_en1, w_ul1, w_dl1), 32'd0);
    end
    rst = 1'b0;
    tick();
    check("t1 post dut0", pk(w_up0, w_dn0, w_en0, w_ul0, w_dl0), 32'd0);
    check("t1 post dut1", pk(w_up1, w_dn1, w_en1, w_ul1, w_dl1), 32'd0);

    // 2: no-repeat instance, btn_up held 30 cycles then released.
    r_b0_up = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      eu = (k == 6);
      check($sformatf("t2 k=%0d", k), pk(w_up0, w_dn0, w_en0, w_ul0, w_dl0),
            pk(eu, 1'b0, eu, (k >= 5), 1'b0));
    end
    r_b0_up = 1'b0;
    for (int k = 30; k < 40; k++) begin
      tick();
      check($sformatf("t2 rel k=%0d", k), pk(w_up0, w_dn0, w_en0, w_ul0, w_dl0),
            pk(1'b0, 1'b0, 1'b0, (k < 35), 1'b0));
    end

    // 3: bounce (toggle every 2 cycles for 12 cycles) then steady from T=12.
    do_reset();
    for (int k = 0; k < 31; k++) begin
      r_b1_up = (k >= 12) ? 1'b1 : (((k / 2) % 2) == 0);
      tick();
      eu = (k == 18);
      check($sformatf("t3 k=%0d", k), pk(w_up1, w_dn1, w_en1, w_ul1, w_dl1),
            pk(eu, 1'b0, eu, (k >= 17), 1'b0));
    end

    // 4: btn_down held 70 cycles; repeat at 26 then every 8; release at 70.
    do_reset();
    r_b1_dn = 1'b1;
    for (int k = 0; k < 86; k++) begin
      if (k == 70) r_b1_dn = 1'b0;
      tick();
      ed = (k == 6) || (k >= 26 && k <= 74 && ((k - 26) % 8) == 0);
      check($sformatf("t4 k=%0d", k), pk(w_up1, w_dn1, w_en1, w_ul1, w_dl1),
            pk(1'b0, ed, ed, 1'b0, (k >= 5 && k < 75)));
    end

    // 5: both pressed together, then btn_up dropped at edge 30.
    do_reset();
    r_b1_up = 1'b1;
    r_b1_dn = 1'b1;
    for (int k = 0; k < 71; k++) begin
      if (k == 30) r_b1_up = 1'b0;
      tick();
      ed  = (k == 55) || (k == 63);
      eul = (k >= 5 && k < 35);
      edl = (k >= 5);
      check($sformatf("t5 k=%0d", k), pk(w_up1, w_dn1, w_en1, w_ul1, w_dl1),
            pk(1'b0, ed, ed, eul, edl));
    end

    // 6: reset pulse in the middle of a down repeat with the button held.
    do_reset();
    r_b1_dn = 1'b1;
    for (int k = 0; k < 36; k++) begin
      tick();
      ed = (k == 6) || (k == 26) || (k == 34);
      check($sformatf("t6 pre k=%0d", k), pk(w_up1, w_dn1, w_en1, w_ul1, w_dl1),
            pk(1'b0, ed, ed, 1'b0, (k >= 5)));
    end
    rst = 1'b1;
    tick();
    check("t6 in rst", pk(w_up1, w_dn1, w_en1, w_ul1, w_dl1), 32'd0);
    rst = 1'b0;
    for (int m = 0; m < 41; m++) begin
      tick();
      ed = (m == 6) || (m == 26) || (m == 34);
      check($sformatf("t6 post m=%0d", m), pk(w_up1, w_dn1, w_en1, w_ul1, w_dl1),
            pk(1'b0, ed, ed, 1'b0, (m >= 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
